amo_unit: RTL and testbench

//  Executes RV32A atomics (LR.W, SC.W, AMO*.W) in the memory stage, downstream of the atomic ALU decoder.

---
 rtl/atomic_pkg.sv | 43 ++++
 rtl/amo_alu.sv | 33 +++
 rtl/amo_unit.sv | 158 +++++++++++++++
 tb/tb_amo_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atomic_pkg.sv
// Shared types for the RV32A atomic unit.
// AMO_MINMAX_EN (optional define) makes the MIN/MAX/MINU/MAXU encodings legal.
package atomic_pkg;

  localparam logic [1:0] ALUOP_LRSC = 2'b00;
  localparam logic [1:0] ALUOP_AMO  = 2'b01;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } amo_state_e;

  // Legal funct5 values for the AMO (aluop=01) group.
  function automatic logic is_legal_amo(input logic [4:0] f5);
    logic ok;
    ok = 1'b0;
    case (f5)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND: ok = 1'b1;
`ifdef AMO_MINMAX_EN
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU:        ok = 1'b1;
`endif
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational modify step of an AMO: new = op(old, src).
// Min/max variants exist only when AMO_MINMAX_EN is defined.
module amo_alu
  import atomic_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      funct5_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  output logic [XLEN-1:0] new_o
);

  // Select the value written back to memory; unknown ops leave memory unchanged.
  always_comb begin
    new_o = old_i;
    case (funct5_i)
      AMO_ADD:  new_o = old_i + src_i;
      AMO_SWAP: new_o = src_i;
      AMO_XOR:  new_o = old_i ^ src_i;
      AMO_OR:   new_o = old_i | src_i;
      AMO_AND:  new_o = old_i & src_i;
`ifdef AMO_MINMAX_EN
      AMO_MIN:  new_o = ($signed(old_i) < $signed(src_i)) ? old_i : src_i;
      AMO_MAX:  new_o = ($signed(old_i) < $signed(src_i)) ? src_i : old_i;
      AMO_MINU: new_o = (old_i < src_i) ? old_i : src_i;
      AMO_MAXU: new_o = (old_i < src_i) ? src_i : old_i;
`endif
      default:  new_o = old_i;
    endcase
  end

endmodule

// File: rtl/amo_unit.sv
// RV32A atomic sequencer: LR/SC with a single reservation, AMO read-modify-write
// over a req/ack memory port. AMO_MINMAX_EN enables the min/max AMOs.
module amo_unit
  import atomic_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RSV_GRAIN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      aluop,
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] src,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd_data,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  input  logic            snoop_wr,
  input  logic [XLEN-1:0] snoop_addr
);

  amo_state_e      state_q;
  logic [4:0]      f5_q;
  logic [XLEN-1:0] addr_q, src_q, rd_data_q, mem_addr_q, mem_wdata_q, rsv_addr_q, amo_new;
  logic            busy_q, done_q, err_q, mem_req_q, mem_we_q, rsv_valid_q;
  logic            misaligned, illegal, snoop_hit, snoop_lr, sc_ok;

  // Granule offset bits of the snooped address never take part in matching.
  logic unused_snoop_lo;
  assign unused_snoop_lo = ^snoop_addr[RSV_GRAIN-1:0];

  assign misaligned = |addr[1:0];
  assign illegal    = (aluop == ALUOP_LRSC) ? !(funct5 == AMO_LR || funct5 == AMO_SC)
                                            : !is_legal_amo(funct5);
  // Snoop against the live reservation, and against the address an LR is about to reserve.
  assign snoop_hit  = snoop_wr && rsv_valid_q &&
                      (snoop_addr[XLEN-1:RSV_GRAIN] == rsv_addr_q[XLEN-1:RSV_GRAIN]);
  assign snoop_lr   = snoop_wr && (snoop_addr[XLEN-1:RSV_GRAIN] == addr_q[XLEN-1:RSV_GRAIN]);
  // A snoop in the same cycle as the SC check makes the SC fail.
  assign sc_ok      = rsv_valid_q && !snoop_hit &&
                      (addr[XLEN-1:RSV_GRAIN] == rsv_addr_q[XLEN-1:RSV_GRAIN]);

  // Read data feeds the ALU directly so the write request follows the read ack back-to-back.
  amo_alu #(.XLEN(XLEN)) u_alu (
    .funct5_i (f5_q),
    .old_i    (mem_rdata),
    .src_i    (src_q),
    .new_o    (amo_new)
  );

  // Sequencer and reservation; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      f5_q        <= '0;
      addr_q      <= '0;
      src_q       <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // Default snoop clear; LR/SC updates below take precedence where they apply.
      if (snoop_hit) rsv_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !aluop[1]) begin
            f5_q      <= funct5;
            addr_q    <= addr;
            src_q     <= src;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            if (misaligned || illegal) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_RESP;
            end else if (aluop == ALUOP_LRSC && funct5 == AMO_SC) begin
              rsv_valid_q <= 1'b0;
              if (sc_ok) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
                mem_wdata_q <= src;
                state_q     <= ST_WRITE;
              end else begin
                rd_data_q <= {{(XLEN-1){1'b0}}, 1'b1};
                done_q    <= 1'b1;
                state_q   <= ST_RESP;
              end
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {addr[XLEN-1:2], 2'b00};
              state_q    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            // LR result and AMO old value both come from the read.
            rd_data_q <= mem_rdata;
            if (f5_q == AMO_LR) begin
              mem_req_q   <= 1'b0;
              rsv_valid_q <= !snoop_lr;
              rsv_addr_q  <= addr_q;
              done_q      <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= amo_new;
              state_q     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (f5_q == AMO_SC) rd_data_q <= '0;
            done_q  <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_amo_unit.sv
// Scoreboard bench for amo_unit: reference model of memory + reservation,
// randomized memory ack latency, directed cases plus random op mix.
module tb_amo_unit;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [4:0]  funct5 = 5'd0;
  logic [31:0] addr = '0, src = '0, snoop_addr = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0, snoop_wr = 1'b0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rd_data, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  amo_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct5(funct5),
    .addr(addr), .src(src), .busy(busy), .done(done), .rd_data(rd_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .snoop_wr(snoop_wr), .snoop_addr(snoop_addr)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          nreq;
    int          nwr;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          total = 0, bad = 0;
  logic [31:0] dmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_rv = 1'b0;
  logic [31:0] ref_ra = '0;
  int          req_cnt = 0, wr_cnt = 0, req_base = 0, wr_base = 0;
  int          force_dly = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic bit amo_ok(input logic [4:0] f);
    bit ok;
    ok = (f == 5'd0 || f == 5'd1 || f == 5'd4 || f == 5'd8 || f == 5'd12);
`ifdef AMO_MINMAX_EN
    ok = ok || (f == 5'd16 || f == 5'd20 || f == 5'd24 || f == 5'd28);
`endif
    return ok;
  endfunction

  function automatic logic [31:0] amo_calc(input logic [4:0] f, input logic [31:0] o, input logic [31:0] s);
    case (f)
      5'd0:    return o + s;
      5'd1:    return s;
      5'd4:    return o ^ s;
      5'd8:    return o | s;
      5'd12:   return o & s;
      5'd16:   return ($signed(o) < $signed(s)) ? o : s;
      5'd20:   return ($signed(o) > $signed(s)) ? o : s;
      5'd24:   return (o < s) ? o : s;
      5'd28:   return (o > s) ? o : s;
      default: return o;
    endcase
  endfunction

  // Memory responder: random (or forced) ack delay, request stability checks.
  bit          pend = 1'b0;
  int          wcnt = 0;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wd;
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    if (!rst_n) pend = 1'b0;
    else if (mem_req) begin
      if (!pend) begin
        pend = 1'b1;
        req_cnt++;
        wcnt = (force_dly >= 0) ? force_dly : $urandom_range(0, 3);
        snap_we = mem_we; snap_addr = mem_addr; snap_wd = mem_wdata;
        check("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
      end else begin
        check("hold_we", 32'(mem_we), 32'(snap_we));
        check("hold_addr", mem_addr, snap_addr);
        if (snap_we) check("hold_wdata", mem_wdata, snap_wd);
      end
      if (wcnt == 0) begin
        mem_ack = 1'b1;
        pend = 1'b0;
        if (mem_we) begin
          dmem[mem_addr] = mem_wdata;
          wr_cnt++;
        end else mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : 32'h0;
      end else wcnt--;
    end else pend = 1'b0;
  end

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got done=1 want no response");
      end else begin
        mon_e = expq.pop_front();
        check("rd_data", rd_data, mon_e.rd);
        check("err", 32'(err), 32'(mon_e.err));
        check("num_mem_req", 32'(req_cnt - req_base), 32'(mon_e.nreq));
        check("num_mem_wr", 32'(wr_cnt - wr_base), 32'(mon_e.nwr));
      end
      req_base = req_cnt;
      wr_base  = wr_cnt;
    end
  end

  // Issue one op, model it, wait for done. snp holds a snoop for the whole op.
  // poke>0: extra start on that busy cycle; poke<0: extra start in the RESP cycle.
  task automatic run_op(input logic [1:0] op, input logic [4:0] f5, input logic [31:0] a,
                        input logic [31:0] s, input bit snp, input logic [31:0] sa,
                        input int poke, output int lat);
    exp_t        e;
    bit          acc, legal, ok;
    logic [31:0] w, old;
    acc = !op[1];
    w   = {a[31:2], 2'b00};
    if (snp && ref_rv && (sa >> 2) == (ref_ra >> 2)) ref_rv = 1'b0;
    if (acc) begin
      e.rd = '0; e.err = 1'b0; e.nreq = 0; e.nwr = 0;
      legal = (op == 2'b00) ? (f5 == 5'd2 || f5 == 5'd3) : amo_ok(f5);
      if (a[1:0] != 2'b00 || !legal) e.err = 1'b1;
      else if (op == 2'b00 && f5 == 5'd2) begin
        e.rd = ref_rd(w); e.nreq = 1;
        ref_rv = !(snp && (sa >> 2) == (a >> 2));
        ref_ra = a;
      end else if (op == 2'b00) begin
        ok = ref_rv && (ref_ra >> 2) == (a >> 2);
        ref_rv = 1'b0;
        if (ok) begin ref_mem[w] = s; e.nreq = 1; e.nwr = 1; e.rd = 32'd0; end
        else e.rd = 32'd1;
      end else begin
        old = ref_rd(w);
        ref_mem[w] = amo_calc(f5, old, s);
        e.rd = old; e.nreq = 2; e.nwr = 1;
      end
      expq.push_back(e);
    end
    aluop = op; funct5 = f5; addr = a; src = s; start = 1'b1;
    snoop_wr = snp; snoop_addr = sa;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    if (acc) begin
      check("busy_after_start", 32'(busy), 32'd1);
      if (poke > 0) begin aluop = 2'b01; funct5 = 5'd0; addr = 32'h104; end
      while (!done && lat < 200) begin
        @(negedge clk);
        lat++;
        start = (poke > 0 && lat == poke);
      end
      start = 1'b0;
      if (!done) begin
        total++; bad++;
        $display("FAIL done_timeout: got no done within %0d cycles want done", lat);
      end
      if (poke < 0) begin aluop = 2'b01; funct5 = 5'd0; addr = 32'h104; start = 1'b1; end
    end else check("busy_ignored", 32'(busy), 32'd0);
    snoop_wr = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [31:0] addrs[4] = '{32'h100, 32'h104, 32'h200, 32'h300};
  logic [4:0]  f5s[11]  = '{5'd0, 5'd1, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28, 5'd2, 5'd7};

  initial begin
    int          lat, r;
    logic [31:0] a, sa, v;
    bit          snp;

    foreach (addrs[i]) begin
      v = $urandom;
      dmem[addrs[i]] = v; ref_mem[addrs[i]] = v;
    end
    dmem[32'h100] = 32'h5;        ref_mem[32'h100] = 32'h5;
    dmem[32'h200] = 32'hFFFFFFFF; ref_mem[32'h200] = 32'hFFFFFFFF;
    dmem[32'h300] = 32'hFFFFFFFE; ref_mem[32'h300] = 32'hFFFFFFFE;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({busy, done, err, mem_req, mem_we}), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LR then SC succeeds.
    run_op(2'b00, 5'd2, 32'h100, 32'h0, 1'b0, 32'h0, 0, lat);
    run_op(2'b00, 5'd3, 32'h100, 32'h9, 1'b0, 32'h0, 0, lat);
    check("sc_mem_written", dmem[32'h100], 32'h9);
    // Second SC has no reservation left.
    run_op(2'b00, 5'd3, 32'h100, 32'h1234, 1'b0, 32'h0, 0, lat);

    // LR, idle-time snoop on same word, SC fails.
    run_op(2'b00, 5'd2, 32'h100, 32'h0, 1'b0, 32'h0, 0, lat);
    run_op(2'b10, 5'd0, 32'h0, 32'h0, 1'b1, 32'h101, 0, lat);
    run_op(2'b00, 5'd3, 32'h100, 32'hAA, 1'b0, 32'h0, 0, lat);
    check("snooped_sc_mem", dmem[32'h100], 32'h9);

    // LR with a concurrent snoop of the same granule never reserves.
    run_op(2'b00, 5'd2, 32'h104, 32'h0, 1'b1, 32'h106, 0, lat);
    run_op(2'b00, 5'd3, 32'h104, 32'h55, 1'b0, 32'h0, 0, lat);
    // Snoop in the SC cycle fails the SC.
    run_op(2'b00, 5'd2, 32'h104, 32'h0, 1'b0, 32'h0, 0, lat);
    run_op(2'b00, 5'd3, 32'h104, 32'h66, 1'b1, 32'h104, 0, lat);

    // AMOADD wraps, ack held off 3 cycles on every request.
    force_dly = 3;
    run_op(2'b01, 5'd0, 32'h200, 32'h2, 1'b0, 32'h0, 0, lat);
    check("amoadd_mem", dmem[32'h200], 32'h1);
    force_dly = -1;

    // Misaligned AMOSWAP: error, no memory traffic.
    run_op(2'b01, 5'd1, 32'h202, 32'h7, 1'b0, 32'h0, 0, lat);
    check("err_latency_le2", 32'(lat <= 2), 32'd1);

    // AMOMAX: legal only with the min/max build.
    run_op(2'b01, 5'd20, 32'h300, 32'h1, 1'b0, 32'h0, 0, lat);
`ifdef AMO_MINMAX_EN
    check("amomax_mem", dmem[32'h300], 32'h1);
`else
    check("amomax_mem", dmem[32'h300], 32'hFFFFFFFE);
`endif

    // Starts while busy and during RESP are ignored.
    force_dly = 3;
    run_op(2'b00, 5'd2, 32'h104, 32'h0, 1'b0, 32'h0, 2, lat);
    force_dly = -1;
    run_op(2'b01, 5'd8, 32'h104, 32'hF0, 1'b0, 32'h0, -1, lat);
    @(negedge clk);
    check("resp_start_ignored", 32'(busy), 32'd0);

    // Reset while an SC write waits for ack.
    run_op(2'b00, 5'd2, 32'h100, 32'h0, 1'b0, 32'h0, 0, lat);
    v = dmem[32'h100];
    force_dly = 50;
    aluop = 2'b00; funct5 = 5'd3; addr = 32'h100; src = 32'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!(mem_req && mem_we) && lat < 20) begin @(negedge clk); lat++; end
    check("sc_write_pending", 32'({mem_req, mem_we}), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'({mem_req, busy, done}), 32'd0);
    ref_rv = 1'b0;
    force_dly = -1;
    @(negedge clk);
    rst_n = 1'b1;
    req_base = req_cnt; wr_base = wr_cnt;
    @(negedge clk);
    check("rst_mem_untouched", dmem[32'h100], v);
    run_op(2'b00, 5'd3, 32'h100, 32'h77, 1'b0, 32'h0, 0, lat);
    run_op(2'b00, 5'd2, 32'h100, 32'h0, 1'b0, 32'h0, 0, lat);
    run_op(2'b00, 5'd3, 32'h100, 32'h88, 1'b0, 32'h0, 0, lat);
    check("post_rst_sc_mem", dmem[32'h100], 32'h88);

    // Random mix.
    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 9);
      a   = addrs[$urandom_range(0, 3)];
      if ($urandom_range(0, 11) == 0) a = a | 32'($urandom_range(1, 3));
      snp = ($urandom_range(0, 5) == 0);
      sa  = addrs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      if (r <= 2)      run_op(2'b00, 5'd2, a, $urandom, snp, sa, 0, lat);
      else if (r <= 5) begin
        if ($urandom_range(0, 9) < 7) a = ref_ra;
        run_op(2'b00, 5'd3, a, $urandom, snp, sa, 0, lat);
      end
      else if (r <= 8) run_op(2'b01, f5s[$urandom_range(0, 10)], a, $urandom, snp, sa, 0, lat);
      else             run_op(2'($urandom_range(2, 3)), 5'd2, a, $urandom, snp, sa, 0, lat);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    foreach (ref_mem[k]) check("final_mem", dmem.exists(k) ? dmem[k] : 32'h0, ref_mem[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
